// File: rtl/cordic_iter_sched.sv
// cordic_iter_sched: round-robin scheduler sharing one folded CORDIC datapath
// between two requesters. It drives load/iterate/shift/direction controls for
// N_PE micro-rotations, then presents the tagged result until it is consumed.
// This block contains no arithmetic; the x/y/z registers live in the datapath.
module cordic_iter_sched #(
    parameter int N_PE   = 13,
    parameter int ITER_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_req_valid,
    output logic [1:0]        o_req_ready,
    input  logic [1:0]        i_req_mode,
    output logic              o_load,
    output logic              o_sel,
    output logic              o_iter_en,
    output logic [ITER_W-1:0] o_shift,
    output logic              o_dir,
    input  logic              i_z_sign,
    input  logic              i_y_sign,
    output logic              o_res_valid,
    output logic              o_res_id,
    input  logic              i_res_ready,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value of the final micro-rotation.
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_PE - 1);

    state_t              state;
    logic [ITER_W-1:0]   counter;
    logic                owner;
    logic                mode;
    logic                last;
    logic                iter_en;
    logic                res_valid;
    logic                res_id;
    logic                busy;

    logic                grant;
    logic                grant_valid;

    // Round-robin grant, only offered in IDLE; gated by reset so nothing is
    // accepted while the block is being reset.
    always_comb begin
        grant       = 1'b0;
        grant_valid = 1'b0;
        if (state == IDLE && !i_rst) begin
            case (i_req_valid)
                2'b01: begin
                    grant       = 1'b0;
                    grant_valid = 1'b1;
                end
                2'b10: begin
                    grant       = 1'b1;
                    grant_valid = 1'b1;
                end
                2'b11: begin
                    grant       = ~last;
                    grant_valid = 1'b1;
                end
                default: begin
                    grant       = 1'b0;
                    grant_valid = 1'b0;
                end
            endcase
        end
    end

    // Handshake and mux controls are combinational so a request is accepted in
    // the same cycle it is presented; the mux keeps the owner selected otherwise.
    always_comb begin
        o_req_ready = 2'b00;
        if (grant_valid) begin
            o_req_ready = grant ? 2'b10 : 2'b01;
        end
        o_load = grant_valid;
        o_sel  = grant_valid ? grant : owner;
    end

    // Rotation steers z toward zero, vectoring steers y toward zero; the sign
    // inputs change every iteration so direction cannot be registered.
    always_comb begin
        o_dir = 1'b0;
        if (iter_en) begin
            o_dir = mode ? i_y_sign : ~i_z_sign;
        end
    end

    assign o_iter_en   = iter_en;
    assign o_shift     = counter;
    assign o_res_valid = res_valid;
    assign o_res_id    = res_id;
    assign o_busy      = busy;

    // Scheduler FSM; status outputs are registered alongside the state, and the
    // counter is cleared on leaving ITER so the shift index reads 0 elsewhere.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            counter   <= '0;
            owner     <= 1'b0;
            mode      <= 1'b0;
            last      <= 1'b1;
            iter_en   <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner   <= grant;
                        mode    <= i_req_mode[grant];
                        last    <= grant;
                        counter <= '0;
                        iter_en <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ITER;
                    end
                end
                ITER: begin
                    if (counter == LAST_ITER) begin
                        counter   <= '0;
                        iter_en   <= 1'b0;
                        res_valid <= 1'b1;
                        res_id    <= owner;
                        state     <= DONE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                DONE: begin
                    if (i_res_ready) begin
                        res_valid <= 1'b0;
                        res_id    <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    counter   <= '0;
                    iter_en   <= 1'b0;
                    res_valid <= 1'b0;
                    res_id    <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_iter_sched.sv
// tb_cordic_iter_sched: directed testbench for the CORDIC iteration scheduler.
// Inputs change just after the falling edge and outputs are sampled 1 ns later,
// well away from the rising edge.
module tb_cordic_iter_sched;

    localparam int N_PE   = 13;
    localparam int ITER_W = 4;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_mode;
    logic              load;
    logic              sel;
    logic              iter_en;
    logic [ITER_W-1:0] shift;
    logic              dir;
    logic              z_sign;
    logic              y_sign;
    logic              res_valid;
    logic              res_id;
    logic              res_ready;
    logic              busy;

    int checks;
    int failures;

    wire [13:0] all_outs = {req_ready, load, sel, iter_en, shift, dir,
                            res_valid, res_id, busy};

    cordic_iter_sched #(
        .N_PE   (N_PE),
        .ITER_W (ITER_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_mode  (req_mode),
        .o_load      (load),
        .o_sel       (sel),
        .o_iter_en   (iter_en),
        .o_shift     (shift),
        .o_dir       (dir),
        .i_z_sign    (z_sign),
        .i_y_sign    (y_sign),
        .o_res_valid (res_valid),
        .o_res_id    (res_id),
        .i_res_ready (res_ready),
        .o_busy      (busy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pulses reset; returns at a falling edge with reset just released
    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 2'b00; req_mode = 2'b00;
        z_sign = 1'b0; y_sign = 1'b0; res_ready = 1'b0;
        #3;
        checks++;
        if (all_outs !== 14'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b expected 0", all_outs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (all_outs !== 14'd0) begin
                failures++;
                $display("[TB] FAIL idle_outputs cycle %0d: got %b expected 0", i, all_outs);
            end
        end
    endtask

    task automatic test_single;
        @(negedge clk);
        req_valid = 2'b01; req_mode = 2'b00; z_sign = 1'b0;
        #1;
        checks++;
        if ({req_ready, load, sel, iter_en, busy} !== {2'b01, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL single_grant: got ready=%b load=%b sel=%b iter=%b busy=%b expected 01 1 0 0 0",
                     req_ready, load, sel, iter_en, busy);
        end
        for (int i = 0; i < N_PE; i++) begin
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            checks++;
            if ({iter_en, shift, load, req_ready, busy, dir, res_valid} !==
                {1'b1, ITER_W'(i), 1'b0, 2'b00, 1'b1, 1'b1, 1'b0}) begin
                failures++;
                $display("[TB] FAIL single_iter %0d: got iter=%b shift=%0d load=%b ready=%b busy=%b dir=%b rv=%b expected 1 %0d 0 00 1 1 0",
                         i, iter_en, shift, load, req_ready, busy, dir, res_valid, i);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({res_valid, res_id, iter_en, shift, dir, busy} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL single_done: got rv=%b id=%b iter=%b shift=%0d dir=%b busy=%b expected 1 0 0 0 0 1",
                     res_valid, res_id, iter_en, shift, dir, busy);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checks++;
        if ({busy, res_valid} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL single_return_idle: got busy=%b rv=%b expected 0 0", busy, res_valid);
        end
    endtask

    task automatic test_round_robin;
        int ngrant;
        int nres;
        int last_cycle;
        logic [1:0] exp_ready;
        ngrant = 0; nres = 0; last_cycle = 0;
        do_reset();
        req_valid = 2'b11; req_mode = 2'b00; res_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_ready !== 2'b00) begin
                exp_ready = (ngrant % 2 == 0) ? 2'b01 : 2'b10;
                checks++;
                if (req_ready !== exp_ready) begin
                    failures++;
                    $display("[TB] FAIL rr_grant %0d: got %b expected %b", ngrant, req_ready, exp_ready);
                end
                if (ngrant > 0) begin
                    checks++;
                    if (c - last_cycle != N_PE + 2) begin
                        failures++;
                        $display("[TB] FAIL rr_spacing %0d: got %0d expected %0d", ngrant, c - last_cycle, N_PE + 2);
                    end
                end
                last_cycle = c;
                ngrant++;
            end
            if (res_valid === 1'b1) begin
                checks++;
                if (res_id !== 1'(nres % 2)) begin
                    failures++;
                    $display("[TB] FAIL rr_res_id %0d: got %b expected %0d", nres, res_id, nres % 2);
                end
                nres++;
            end
        end
        checks++;
        if (ngrant != 4 || nres != 4) begin
            failures++;
            $display("[TB] FAIL rr_counts: got grants=%0d results=%0d expected 4 4", ngrant, nres);
        end
        @(negedge clk);
        req_valid = 2'b00; res_ready = 1'b0;
    endtask

    task automatic test_done_stall;
        do_reset();
        req_valid = 2'b11; req_mode = 2'b00; res_ready = 1'b0; z_sign = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("[TB] FAIL stall_first_grant: got %b expected 01", req_ready);
        end
        for (int i = 0; i < N_PE; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({req_ready, iter_en} !== {2'b00, 1'b1}) begin
                failures++;
                $display("[TB] FAIL stall_iter_ready %0d: got ready=%b iter=%b expected 00 1", i, req_ready, iter_en);
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({res_valid, res_id, req_ready, iter_en, load} !== {1'b1, 1'b0, 2'b00, 1'b0, 1'b0}) begin
                failures++;
                $display("[TB] FAIL stall_hold %0d: got rv=%b id=%b ready=%b iter=%b load=%b expected 1 0 00 0 0",
                         i, res_valid, res_id, req_ready, iter_en, load);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        checks++;
        if ({res_valid, req_ready} !== {1'b1, 2'b00}) begin
            failures++;
            $display("[TB] FAIL stall_accept_cycle: got rv=%b ready=%b expected 1 00", res_valid, req_ready);
        end
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checks++;
        if ({busy, res_valid, req_ready, load, sel} !== {1'b0, 1'b0, 2'b10, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL stall_next_grant: got busy=%b rv=%b ready=%b load=%b sel=%b expected 0 0 10 1 1",
                     busy, res_valid, req_ready, load, sel);
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic test_direction;
        do_reset();
        req_valid = 2'b01; req_mode = 2'b00; z_sign = 1'b0; y_sign = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        req_valid = 2'b00; z_sign = 1'b1; y_sign = 1'b1;
        #1;
        checks++;
        if (dir !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dir_rot_zneg: got %b expected 0", dir);
        end
        @(negedge clk);
        z_sign = 1'b0; y_sign = 1'b1;
        #1;
        checks++;
        if (dir !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dir_rot_zpos: got %b expected 1", dir);
        end
        for (int i = 2; i < N_PE; i++) @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({res_valid, dir} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL dir_outside_iter: got rv=%b dir=%b expected 1 0", res_valid, dir);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0; req_valid = 2'b10; req_mode = 2'b10;
        #1;
        checks++;
        if ({req_ready, sel} !== {2'b10, 1'b1}) begin
            failures++;
            $display("[TB] FAIL dir_vec_grant: got ready=%b sel=%b expected 10 1", req_ready, sel);
        end
        @(negedge clk);
        req_valid = 2'b00; req_mode = 2'b00; y_sign = 1'b1; z_sign = 1'b0;
        #1;
        checks++;
        if (dir !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dir_vec_yneg: got %b expected 1", dir);
        end
        @(negedge clk);
        z_sign = 1'b1;
        #1;
        checks++;
        if (dir !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dir_vec_ztoggle: got %b expected 1", dir);
        end
        @(negedge clk);
        y_sign = 1'b0;
        #1;
        checks++;
        if (dir !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dir_vec_ypos: got %b expected 0", dir);
        end
        @(negedge clk);
        z_sign = 1'b0;
        #1;
        checks++;
        if (dir !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dir_vec_mode_latched: got %b expected 0", dir);
        end
        for (int i = 4; i < N_PE; i++) @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({res_valid, res_id} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL dir_vec_result: got rv=%b id=%b expected 1 1", res_valid, res_id);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0; y_sign = 1'b0; z_sign = 1'b0;
    endtask

    task automatic test_reset_mid_iter;
        do_reset();
        req_valid = 2'b01; req_mode = 2'b00; z_sign = 1'b0; res_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req_valid = 2'b00;
        end
        #1;
        checks++;
        if ({iter_en, shift} !== {1'b1, 4'd6}) begin
            failures++;
            $display("[TB] FAIL midrst_before: got iter=%b shift=%0d expected 1 6", iter_en, shift);
        end
        #1;
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        checks++;
        if (all_outs !== 14'd0) begin
            failures++;
            $display("[TB] FAIL midrst_async_clear: got %b expected 0", all_outs);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, load, sel} !== {2'b01, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL midrst_pointer: got ready=%b load=%b sel=%b expected 01 1 0", req_ready, load, sel);
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    // Run every scenario in order, then report
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_done_stall();
        test_direction();
        test_reset_mid_iter();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
